// File: rtl/mdu_if.sv
// EX-stage <-> multiply/divide sequencer connection: request, operands, HI/LO and status.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rd_req;
    logic             wr_hi;
    logic             wr_lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, funct, a, b, rd_req, wr_hi, wr_lo,
        input  busy, stall, done, div_zero, hi, lo
    );

    modport slave (
        input  start, funct, a, b, rd_req, wr_hi, wr_lo,
        output busy, stall, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative mult/multu/div/divu sequencer with HI/LO registers and pipeline stall.
// Optional MDU_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module mdu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic   clk,
    input logic   rst_n,
    mdu_if.slave  bus
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_DIVU = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

    state_t           state;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] opb;
    logic [CNT_W-1:0] cnt;
    logic             op_div, op_signed, sgn_q, sgn_r;
    logic             busy, done, div_zero;
    logic [WIDTH-1:0] hi, lo;
`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] mq;
`endif

    // Decode of the EX op and operand magnitudes; unknown funct falls through as multu
    logic             is_signed_c, is_div_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    always_comb begin
        is_signed_c = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        is_div_c    = (bus.funct == F_DIV) || (bus.funct == F_DIVU);
        mag_a_c     = (is_signed_c && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b_c     = (is_signed_c && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // One iteration: shift-add multiply ({acc_hi, multiplier}) or restoring divide ({rem, quo})
    logic [WIDTH:0]  mul_sum_c, rem_sh_c, diff_c;
    logic [W2-1:0]   acc_nxt_c;
    logic            last_c;
    always_comb begin
        mul_sum_c = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        rem_sh_c  = acc[W2-1:WIDTH-1];
        diff_c    = rem_sh_c - {1'b0, opb};
        if (op_div) begin
            acc_nxt_c = diff_c[WIDTH] ? {rem_sh_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt_c = {mul_sum_c, acc[WIDTH-1:1]};
        end
        last_c = (cnt == '0);
`ifdef MDU_EARLY_OUT_EN
        if (!op_div && (mq[WIDTH-1:1] == '0)) last_c = 1'b1;
`endif
    end

    // Final alignment and sign fixup; cnt holds the outstanding shift after an early exit
    logic [W2-1:0]    prod_c, prod_fix_c;
    logic [WIDTH-1:0] quo_c, rem_c;
    always_comb begin
`ifdef MDU_EARLY_OUT_EN
        prod_c = acc >> cnt;
`else
        prod_c = acc;
`endif
        prod_fix_c = (op_signed && sgn_q) ? -prod_c : prod_c;
        quo_c      = (op_signed && sgn_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_c      = (op_signed && sgn_r) ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            opb       <= '0;
            cnt       <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            sgn_q     <= 1'b0;
            sgn_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef MDU_EARLY_OUT_EN
            mq        <= '0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_div    <= is_div_c;
                        op_signed <= is_signed_c;
                        sgn_q     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        sgn_r     <= bus.a[WIDTH-1];
                        cnt       <= CNT_W'(WIDTH - 1);
                        busy      <= 1'b1;
                        if (is_div_c) begin
                            // upper half starts as the remainder, or carries raw a for /0
                            acc <= {(bus.b == '0) ? bus.a : '0, mag_a_c};
                            opb <= mag_b_c;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, mag_b_c};
                            opb <= mag_a_c;
                        end
`ifdef MDU_EARLY_OUT_EN
                        mq <= mag_b_c;
`endif
                        state <= (is_div_c && (bus.b == '0)) ? ZERO : RUN;
                    end else begin
                        if (bus.wr_hi) hi <= bus.a;
                        if (bus.wr_lo) lo <= bus.a;
                    end
                end
                RUN: begin
                    acc <= acc_nxt_c;
`ifdef MDU_EARLY_OUT_EN
                    mq <= mq >> 1;
`endif
                    if (last_c) state <= FIX;
                    else        cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    if (op_div) begin
                        hi <= rem_c;
                        lo <= quo_c;
                    end else begin
                        {hi, lo} <= prod_fix_c;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                ZERO: begin
                    hi       <= acc[W2-1:WIDTH];
                    lo       <= '1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero;
    assign bus.hi       = hi;
    assign bus.lo       = lo;
    assign bus.stall    = busy & (bus.start | bus.rd_req | bus.wr_hi | bus.wr_lo);
endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: latency, HI/LO results, divide-by-zero, stall, reset abort.
module tb_mdu_seq;
    localparam int unsigned WIDTH = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_M7  = 5;   // b=7: 3 RUN cycles
    localparam int LAT_M3  = 4;   // b=3: 2 RUN cycles
`else
    localparam int LAT_M7  = 34;
    localparam int LAT_M3  = 34;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nerr = 0;
    int   nchk = 0;
    int   lat, busy_bad, stall_bad;

    mdu_if #(.WIDTH(WIDTH)) bus ();
    mdu_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for one cycle (cycle 0); returns #1 after the sampling edge
    task automatic go(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        bus.funct = f;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits for done, sampling at negedges; lat is the done cycle, -1 on timeout
    task automatic run_op(output int l, output int bad);
        l   = -1;
        bad = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.done) begin
                if (bus.busy) bad++;
                l = n;
                break;
            end
            if (!bus.busy) bad++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
        bus.rd_req = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // multu max * max
        go(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(lat, busy_bad);
        check("multu_lat", 64'(lat), 64'd34);
        check("multu_busy", 64'(busy_bad), 64'd0);
        check("multu_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        check("multu_dz", 64'(bus.div_zero), 64'd0);

        // signed mult, then div issued in the done cycle
        go(F_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op(lat, busy_bad);
        check("mult_lat", 64'(lat), 64'(LAT_M7));
        check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        go(F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(lat, busy_bad);
        check("div_b2b_lat", 64'(lat), 64'd34);
        check("div_busy", 64'(busy_bad), 64'd0);
        check("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // divu by zero
        go(F_DIVU, 32'h1234_5678, 32'd0);
        run_op(lat, busy_bad);
        check("dz_lat", 64'(lat), 64'd2);
        check("dz_flag", 64'(bus.div_zero), 64'd1);
        check("dz_hilo", {bus.hi, bus.lo}, 64'h1234_5678_FFFF_FFFF);
        @(negedge clk);
        check("dz_pulse", {62'd0, bus.done, bus.div_zero}, 64'd0);

        // most negative / -1
        go(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(lat, busy_bad);
        check("ovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // unknown funct behaves as multu
        go(6'b100000, 32'd6, 32'd7);
        run_op(lat, busy_bad);
        check("unk_hilo", {bus.hi, bus.lo}, 64'd42);

        // stall from rd_req/wr_hi during a multiply
        go(F_MULTU, 32'h0000_0010, 32'h8000_0001);
        stall_bad = 0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end
            if (n == 5) begin
                bus.rd_req = 1'b1;
                bus.wr_hi  = 1'b1;
                bus.a      = 32'hCAFE_0000;
            end
            @(negedge clk);
            if (bus.stall !== ((n >= 5) && (n <= 33))) stall_bad++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        check("stall_lat", 64'(lat), 64'd34);
        check("stall_window", 64'(stall_bad), 64'd0);
        check("stall_lo", {bus.hi, bus.lo}, 64'h0000_0008_0000_0010);
        @(negedge clk);
        check("mthi_after", {bus.hi, bus.lo}, 64'hCAFE_0000_0000_0010);
        bus.rd_req = 1'b0;
        bus.wr_hi  = 1'b0;

        // mtlo in idle
        bus.a     = 32'hDEAD_BEEF;
        bus.wr_lo = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        @(negedge clk);
        check("mtlo", {bus.hi, bus.lo}, 64'hCAFE_0000_DEAD_BEEF);

        // reset aborts a divide in cycle 10
        go(F_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go(F_DIVU, 32'd100, 32'd7);
        run_op(lat, busy_bad);
        check("post_rst_lat", 64'(lat), 64'd34);
        check("post_rst_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

        // small multu (early-out sensitive latency)
        go(F_MULTU, 32'd5, 32'd3);
        run_op(lat, busy_bad);
        check("m53_lat", 64'(lat), 64'(LAT_M3));
        check("m53_hilo", {bus.hi, bus.lo}, 64'd15);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer with its HI/LO register pair, sitting beside the EX-stage ALU.
- Handles mult/multu/div/divu as a multi-cycle operation; serves mfhi/mflo/mthi/mtlo.
- Raises a pipeline stall while a dependent instruction arrives during an operation, so the hazard unit freezes IF/ID/EX until the result is ready.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  EX holds mult/multu/div/divu this cycle.
- funct  input  6  MIPS funct of the EX instruction: 011000 mult, 011001 multu, 011010 div, 011011 divu.
- a  input  WIDTH  rs operand (multiplicand / dividend; mthi/mtlo data).
- b  input  WIDTH  rt operand (multiplier / divisor).
- rd_req  input  1  EX holds mfhi or mflo.
- wr_hi  input  1  EX holds mthi.
- wr_lo  input  1  EX holds mtlo.
- busy  output  1  operation in progress.
- stall  output  1  freeze pipeline; combinational.
- done  output  1  one-cycle pulse; new HI/LO visible this cycle.
- div_zero  output  1  one-cycle pulse with done when the divisor was 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, div_zero = 0; hi, lo = 0; counter = 0. Reset mid-operation aborts it; no HI/LO update.
- States: IDLE, RUN, FIX, ZERO.
- IDLE:
  - start=1 latches operand magnitudes. Signed ops take the two's-complement absolute value of a and b; unsigned ops take them as-is.
  - Latches the result signs: product/quotient sign = a[msb]^b[msb]; remainder sign = a[msb].
  - Loads counter = WIDTH-1.
  - Next state is RUN, or ZERO for div/divu with b==0.
- RUN:
  - One iteration per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements; when counter==0, next state is FIX. WIDTH cycles total.
- FIX:
  - Negates the result where the latched signs require it (signed ops only).
  - Writes HI/LO. Mult: {HI,LO} = product. Div: LO = quotient, HI = remainder.
  - Next state is IDLE.
- ZERO: writes LO = all ones and HI = a (raw, no sign fixup); next state is IDLE.
- Latency:
  - start sampled in cycle 0; busy=1 in cycles 1..WIDTH+1 (RUN plus FIX).
  - done=1 and busy=0 in cycle WIDTH+2, with new hi/lo visible in that cycle.
  - Divide-by-zero: busy in cycle 1, done and div_zero in cycle 2.
- busy is high in RUN, FIX and ZERO.
- stall = busy & (start | rd_req | wr_hi | wr_lo). While stalled, EX inputs are held; the request is serviced in the first cycle busy=0.
- A start arriving in the done cycle is accepted (back-to-back operations).
- mthi/mtlo in IDLE with start=0: hi<=a (wr_hi) and/or lo<=a (wr_lo) at the next edge. start together with wr_hi or wr_lo is illegal; start wins.
- Arithmetic is modulo 2^WIDTH per register. A signed div of -2^(WIDTH-1) by -1 yields LO=0x80000000, HI=0.
- Unknown funct with start=1 is treated as multu.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Multiply leaves RUN as soon as the remaining unshifted multiplier bits are all zero (minimum 1 RUN cycle).
  - The accumulator is aligned by a final barrel shift in FIX.
  - Divide is unchanged.
- Undefined: fixed WIDTH-cycle RUN for every operation.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- mult a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then div a=0xFFFFFFF9 (-7), b=2 issued in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done in cycle 68.
- divu a=0x12345678, b=0 -> done and div_zero in cycle 2; lo=0xFFFFFFFF, hi=0x12345678.
- mult in progress, rd_req=1 at cycle 5 -> stall=1 cycles 5..33, stall=0 in cycle 34 with the new lo readable; wr_hi held during busy -> hi=a one cycle after busy drops.
- rst_n pulled low in cycle 10 of a divu -> busy, done = 0 immediately; hi=lo=0; after release the next start completes normally.
- With MDU_EARLY_OUT_EN: multu a=5, b=3 -> 2 RUN cycles, done in cycle 4, lo=15, hi=0. Without it: done in cycle 34, same result.
